// File: rtl/gemm_pkg.sv
// Shared types and constants for the GEMM job scheduler.
//   - DIM_W / TAG_W / CYC_W : descriptor and report field widths
//   - sched_state_t         : scheduler FSM state encoding
//   - ERR_*                 : completion error codes
//   - gemm_job_t            : queued job descriptor {m,k,n,tag}
//   - dim_ok()              : legal-dimension test (1..max_dim)
package gemm_pkg;

  localparam int DIM_W = 8;
  localparam int TAG_W = 4;
  localparam int CYC_W = 16;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_CHECK     = 3'd1,
    S_ISSUE     = 3'd2,
    S_WAIT_BUSY = 3'd3,
    S_RUN       = 3'd4,
    S_REPORT    = 3'd5
  } sched_state_t;

  localparam logic [1:0] ERR_OK      = 2'd0;
  localparam logic [1:0] ERR_BAD_DIM = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_FLUSHED = 2'd3;

  typedef struct packed {
    logic [DIM_W-1:0] m;
    logic [DIM_W-1:0] k;
    logic [DIM_W-1:0] n;
    logic [TAG_W-1:0] tag;
  } gemm_job_t;

  function automatic logic dim_ok(input logic [DIM_W-1:0] d, input int max_dim);
    return (d != '0) && (int'(d) <= max_dim);
  endfunction

endpackage

// File: rtl/gemm_job_scheduler_if.sv
// Host-side bus of the GEMM job scheduler.
//   job_*   : descriptor push channel (job_valid/job_ready handshake)
//   abort   : flush queued jobs
//   done_*  : completion record channel (done_valid/done_ready handshake)
//   irq     : one-cycle completion pulse
//   queue_count : number of descriptors waiting in the FIFO
// Handshakes: a transfer happens on every rising clock edge where valid and
// ready are both 1; the source holds valid and its payload stable until then.
// Modports: master = host side, slave = scheduler side.
interface gemm_job_scheduler_if #(
  parameter int DEPTH = 4
);
  import gemm_pkg::*;

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             job_valid;
  logic             job_ready;
  logic [DIM_W-1:0] job_m;
  logic [DIM_W-1:0] job_k;
  logic [DIM_W-1:0] job_n;
  logic [TAG_W-1:0] job_tag;
  logic             abort;
  logic             done_valid;
  logic             done_ready;
  logic [TAG_W-1:0] done_tag;
  logic [1:0]       done_err;
  logic [CYC_W-1:0] done_cycles;
  logic             irq;
  logic [CNT_W-1:0] queue_count;

  modport master (
    output job_valid, job_m, job_k, job_n, job_tag, abort, done_ready,
    input  job_ready, done_valid, done_tag, done_err, done_cycles, irq, queue_count
  );

  modport slave (
    input  job_valid, job_m, job_k, job_n, job_tag, abort, done_ready,
    output job_ready, done_valid, done_tag, done_err, done_cycles, irq, queue_count
  );

endinterface

// File: rtl/gemm_job_fifo.sv
// Synchronous descriptor FIFO.
//   push_i/push_data_i : write (ignored when full or flushing)
//   pop_i / head_o     : head entry, removed on pop (ignored when empty)
//   flush_i            : discard all entries in one cycle (wins over push/pop)
//   count_o/full_o/empty_o : occupancy, 0..DEPTH
module gemm_job_fifo import gemm_pkg::*; #(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          push_i,
  input  gemm_job_t     push_data_i,
  input  logic          pop_i,
  input  logic          flush_i,
  output gemm_job_t     head_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);

  gemm_job_t     mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/gemm_job_scheduler.sv
// GEMM job scheduler: queues host descriptors and runs them one at a time
// on the GEMM controller, returning a completion record per job.
//   clk, reset_n        : clock, asynchronous active-low reset
//   bus (slave)         : host job push / abort / completion channel
//   ctrl_in_valid_o     : one-cycle launch pulse to the controller
//   ctrl_m/k/n_o        : job dimensions, held for the whole job
//   ctrl_busy_i         : controller busy
//   state_o             : current FSM state (sched_state_t encoding)
// Flow: IDLE -> CHECK -> ISSUE -> WAIT_BUSY -> RUN -> REPORT -> IDLE.
module gemm_job_scheduler import gemm_pkg::*; #(
  parameter int DEPTH   = 4,
  parameter int MAX_DIM = 4,
  parameter int TIMEOUT = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  gemm_job_scheduler_if.slave bus,
  output logic               ctrl_in_valid_o,
  output logic [DIM_W-1:0]   ctrl_m_o,
  output logic [DIM_W-1:0]   ctrl_k_o,
  output logic [DIM_W-1:0]   ctrl_n_o,
  input  logic               ctrl_busy_i,
  output logic [2:0]         state_o
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [2:0] ST_IDLE      = S_IDLE;
  localparam logic [2:0] ST_CHECK     = S_CHECK;
  localparam logic [2:0] ST_ISSUE     = S_ISSUE;
  localparam logic [2:0] ST_WAIT_BUSY = S_WAIT_BUSY;
  localparam logic [2:0] ST_RUN       = S_RUN;
  localparam logic [2:0] ST_REPORT    = S_REPORT;

  logic [2:0]       state_q, state_d;
  gemm_job_t        job_q, job_d;
  logic [1:0]       err_q, err_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic [DIM_W-1:0] cm_q, cm_d, ck_q, ck_d, cn_q, cn_d;
  logic             ivalid_q, ivalid_d;
  logic             irq_q, irq_d;

  logic             fifo_push;
  logic             fifo_pop;
  gemm_job_t        fifo_in;
  gemm_job_t        fifo_head;
  logic [CW-1:0]    fifo_count;
  logic             fifo_full;
  logic             fifo_empty;
  logic             dims_ok;

  // Ready depends only on occupancy and abort: a pop in the same cycle does
  // not open a slot for a push.
  assign bus.job_ready = !fifo_full && !bus.abort;
  assign fifo_push     = bus.job_valid && bus.job_ready;
  assign fifo_in       = '{m: bus.job_m, k: bus.job_k, n: bus.job_n, tag: bus.job_tag};

  gemm_job_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .reset_n     (reset_n),
    .push_i      (fifo_push),
    .push_data_i (fifo_in),
    .pop_i       (fifo_pop),
    .flush_i     (bus.abort),
    .head_o      (fifo_head),
    .count_o     (fifo_count),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  assign dims_ok = dim_ok(job_q.m, MAX_DIM) && dim_ok(job_q.k, MAX_DIM) &&
                   dim_ok(job_q.n, MAX_DIM);

  always_comb begin
    state_d  = state_q;
    job_d    = job_q;
    err_d    = err_q;
    cyc_d    = cyc_q;
    tmo_d    = tmo_q;
    cm_d     = cm_q;
    ck_d     = ck_q;
    cn_d     = cn_q;
    ivalid_d = 1'b0;
    fifo_pop = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // An abort in this cycle empties the FIFO, so nothing is taken.
        if (!fifo_empty && !bus.abort) begin
          fifo_pop = 1'b1;
          job_d    = fifo_head;
          err_d    = ERR_OK;
          cyc_d    = '0;
          state_d  = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (bus.abort) begin
          err_d   = ERR_FLUSHED;
          state_d = ST_REPORT;
        end else if (!dims_ok) begin
          err_d   = ERR_BAD_DIM;
          state_d = ST_REPORT;
        end else begin
          cm_d     = job_q.m;
          ck_d     = job_q.k;
          cn_d     = job_q.n;
          ivalid_d = 1'b1;
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // The launch pulse is already on the wire here, so an abort no longer
        // cancels the job.
        tmo_d   = '0;
        state_d = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (ctrl_busy_i) begin
          cyc_d   = CYC_W'(1);
          state_d = ST_RUN;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          err_d   = ERR_TIMEOUT;
          state_d = ST_REPORT;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      ST_RUN: begin
        if (ctrl_busy_i) begin
          if (cyc_q != '1) cyc_d = cyc_q + 1'b1;
        end else begin
          err_d   = ERR_OK;
          state_d = ST_REPORT;
        end
      end
      ST_REPORT: begin
        if (bus.done_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    irq_d = (state_d == ST_REPORT) && (state_q != ST_REPORT);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      job_q    <= '0;
      err_q    <= ERR_OK;
      cyc_q    <= '0;
      tmo_q    <= '0;
      cm_q     <= '0;
      ck_q     <= '0;
      cn_q     <= '0;
      ivalid_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      job_q    <= job_d;
      err_q    <= err_d;
      cyc_q    <= cyc_d;
      tmo_q    <= tmo_d;
      cm_q     <= cm_d;
      ck_q     <= ck_d;
      cn_q     <= cn_d;
      ivalid_q <= ivalid_d;
      irq_q    <= irq_d;
    end
  end

  assign bus.done_valid  = (state_q == ST_REPORT);
  assign bus.done_tag    = job_q.tag;
  assign bus.done_err    = err_q;
  assign bus.done_cycles = cyc_q;
  assign bus.irq         = irq_q;
  assign bus.queue_count = fifo_count;

  assign ctrl_in_valid_o = ivalid_q;
  assign ctrl_m_o        = cm_q;
  assign ctrl_k_o        = ck_q;
  assign ctrl_n_o        = cn_q;
  assign state_o         = state_q;

endmodule

// File: tb/tb_gemm_job_scheduler.sv
module tb_gemm_job_scheduler;
  import gemm_pkg::*;

  localparam int DEPTH   = 4;
  localparam int MAX_DIM = 4;
  localparam int TIMEOUT = 8;
  localparam int RW      = TAG_W + 2 + CYC_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic             ctrl_in_valid;
  logic [DIM_W-1:0] ctrl_m, ctrl_k, ctrl_n;
  logic             ctrl_busy = 1'b0;
  logic [2:0]       state;

  gemm_job_scheduler_if #(.DEPTH(DEPTH)) bus();

  gemm_job_scheduler #(.DEPTH(DEPTH), .MAX_DIM(MAX_DIM), .TIMEOUT(TIMEOUT)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .bus             (bus),
    .ctrl_in_valid_o (ctrl_in_valid),
    .ctrl_m_o        (ctrl_m),
    .ctrl_k_o        (ctrl_k),
    .ctrl_n_o        (ctrl_n),
    .ctrl_busy_i     (ctrl_busy),
    .state_o         (state)
  );

  // ---------------- scoreboard state ----------------
  int errors = 0;
  int checks = 0;
  logic [RW-1:0]      exp_q[$];       // expected completion records, push order
  int                 busy_len_q[$];  // busy length per launched job (0 = never busy)
  logic [3*DIM_W-1:0] exp_dims_q[$];  // expected dims per launched job
  int exp_launch = 0;
  int launch_cnt = 0;
  int last_hs_cyc = -1;
  int last_launch_cyc = -1;
  int last_rise_cyc = -1;
  int last_gap = -1;
  bit hold_ready = 1'b0;
  bit rand_ready = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  // Reference model: outcome of a job follows from its dimensions and from
  // how the controller will behave for it.
  task automatic model_accept(input int m, input int k, input int n, input int tag,
                              input int len);
    logic [RW-1:0] rec;
    bit bad;
    bad = (m < 1) || (m > MAX_DIM) || (k < 1) || (k > MAX_DIM) || (n < 1) || (n > MAX_DIM);
    if (bad) begin
      rec = {TAG_W'(tag), ERR_BAD_DIM, CYC_W'(0)};
    end else begin
      exp_launch++;
      busy_len_q.push_back(len);
      exp_dims_q.push_back({DIM_W'(m), DIM_W'(k), DIM_W'(n)});
      if (len == 0) rec = {TAG_W'(tag), ERR_TIMEOUT, CYC_W'(0)};
      else          rec = {TAG_W'(tag), ERR_OK, CYC_W'(len > 65535 ? 65535 : len)};
    end
    exp_q.push_back(rec);
  endtask

  // ---------------- driver tasks (all start at posedge+1) ----------------
  task automatic push_job(input int m, input int k, input int n, input int tag,
                          input int len);
    int waited = 0;
    bus.job_valid = 1'b1;
    bus.job_m = DIM_W'(m);
    bus.job_k = DIM_W'(k);
    bus.job_n = DIM_W'(n);
    bus.job_tag = TAG_W'(tag);
    while (!bus.job_ready && waited < 300) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!bus.job_ready) begin
      check("push_accept_timeout", 0, 1);
      bus.job_valid = 1'b0;
    end else begin
      model_accept(m, k, n, tag, len);
      @(posedge clk); #1;
    end
  endtask

  task automatic idle(input int n);
    bus.job_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_done_valid(input string name);
    int n = 0;
    while (!bus.done_valid && n < 200) begin @(posedge clk); #1; n++; end
    check({name, "_done_valid_seen"}, int'(bus.done_valid), 1);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 4000) begin @(posedge clk); #1; n++; end
    check({name, "_drain_remaining"}, exp_q.size(), 0);
    repeat (6) begin @(posedge clk); #1; end
    check({name, "_launch_count"}, launch_cnt, exp_launch);
  endtask

  // ---------------- done_ready driver ----------------
  initial begin : ready_drv
    bus.done_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (hold_ready)      bus.done_ready = 1'b0;
      else if (rand_ready) bus.done_ready = ($urandom_range(0, 3) != 0);
      else                 bus.done_ready = 1'b1;
    end
  end

  // ---------------- behavioural GEMM controller ----------------
  initial begin : ctrl_model
    int len;
    int dly;
    logic [3*DIM_W-1:0] d;
    forever begin
      @(negedge clk);
      if (reset_n && ctrl_in_valid) begin
        if (exp_dims_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL launch_unexpected: got launch expected none at cycle %0d", cyc);
          len = 0;
        end else begin
          d = exp_dims_q.pop_front();
          len = busy_len_q.pop_front();
          check("launch_dims", int'({ctrl_m, ctrl_k, ctrl_n}), int'(d));
        end
        if (len > 0) begin
          dly = $urandom_range(1, 4);
          repeat (dly) @(negedge clk);
          ctrl_busy = 1'b1;
          for (int i = 0; i < len; i++) begin
            @(negedge clk);
            check("ctrl_dims_hold", int'({ctrl_m, ctrl_k, ctrl_n}), int'(d));
          end
          ctrl_busy = 1'b0;
        end
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin : monitor
    logic prev_dv;
    bit stalled;
    logic [RW-1:0] held;
    logic [RW-1:0] rec;
    logic [RW-1:0] exp;
    prev_dv = 1'b0;
    stalled = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev_dv = 1'b0;
        stalled = 1'b0;
      end else begin
        rec = {bus.done_tag, bus.done_err, bus.done_cycles};
        if (ctrl_in_valid) begin
          launch_cnt++;
          last_launch_cyc = cyc;
          if (last_hs_cyc >= 0) begin
            last_gap = cyc - last_hs_cyc;
            check("launch_gap_ge3", int'(last_gap >= 3), 1);
          end
        end
        if (bus.irq || (bus.done_valid && !prev_dv))
          check("irq_first_report_cycle", int'(bus.irq), int'(bus.done_valid && !prev_dv));
        if (bus.done_valid && !prev_dv) last_rise_cyc = cyc;
        if (stalled) begin
          check("done_stable", int'({bus.done_valid, rec}), int'({1'b1, held}));
          stalled = 1'b0;
        end
        if (bus.done_valid) begin
          if (bus.done_ready) begin
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL done_unexpected: got record 0x%0h expected none", rec);
            end else begin
              exp = exp_q.pop_front();
              check("done_record", int'(rec), int'(exp));
            end
            last_hs_cyc = cyc;
          end else begin
            stalled = 1'b1;
            held = rec;
          end
        end
        prev_dv = bus.done_valid;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got no finish expected finish by time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin : main
    int l0;
    bus.job_valid = 1'b0;
    bus.job_m = '0;
    bus.job_k = '0;
    bus.job_n = '0;
    bus.job_tag = '0;
    bus.abort = 1'b0;
    reset_n = 1'b0;
    repeat (4) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;

    // reset state
    check("rst_job_ready", int'(bus.job_ready), 1);
    check("rst_done_valid", int'(bus.done_valid), 0);
    check("rst_irq", int'(bus.irq), 0);
    check("rst_queue_count", int'(bus.queue_count), 0);
    check("rst_ctrl_in_valid", int'(ctrl_in_valid), 0);
    check("rst_ctrl_dims", int'({ctrl_m, ctrl_k, ctrl_n}), 0);
    check("rst_done_fields", int'({bus.done_tag, bus.done_err, bus.done_cycles}), 0);
    check("rst_state", int'(state), int'(S_IDLE));

    // single 4x4x4 job, busy for 8 cycles
    push_job(4, 4, 4, 3, 8);
    idle(1);
    wait_drain("single");

    // illegal dimensions, then a legal job
    push_job(0, 2, 2, 7, 5);
    push_job(5, 1, 1, 8, 5);
    push_job(2, 2, 2, 9, 3);
    idle(1);
    wait_drain("bad_dim");

    // controller never raises busy
    push_job(3, 3, 3, 10, 0);
    idle(1);
    wait_done_valid("timeout");
    @(negedge clk); #1;
    check("timeout_latency", last_rise_cyc - last_launch_cyc, TIMEOUT + 1);
    @(posedge clk); #1;
    push_job(1, 1, 1, 11, 2);
    idle(1);
    wait_drain("timeout");

    // report held for 20 cycles
    hold_ready = 1'b1;
    push_job(4, 4, 4, 5, 4);
    push_job(2, 2, 2, 6, 3);
    idle(1);
    wait_done_valid("hold");
    l0 = launch_cnt;
    repeat (20) begin @(posedge clk); #1; end
    check("hold_no_launch", launch_cnt, l0);
    check("hold_done_valid", int'(bus.done_valid), 1);
    check("hold_queue_count", int'(bus.queue_count), 1);
    hold_ready = 1'b0;
    begin
      int n = 0;
      while (launch_cnt == l0 && n < 50) begin @(posedge clk); #1; n++; end
    end
    check("hold_release_gap", last_gap, 3);
    wait_drain("hold");

    // five pushes against a stalled scheduler
    hold_ready = 1'b1;
    push_job(2, 3, 4, 9, 2);
    idle(1);
    wait_done_valid("five");
    for (int t = 0; t < 4; t++)
      push_job($urandom_range(1, 4), $urandom_range(1, 4), $urandom_range(1, 4), t,
               $urandom_range(1, 10));
    bus.job_valid = 1'b1;
    bus.job_tag = TAG_W'(4);
    check("five_ready_when_full", int'(bus.job_ready), 0);
    check("five_queue_count_full", int'(bus.queue_count), DEPTH);
    hold_ready = 1'b0;
    push_job(1, 4, 2, 4, 6);
    idle(1);
    wait_drain("five");

    // abort while a job is running with three queued
    push_job(4, 4, 4, 1, 20);
    idle(1);
    begin
      int n = 0;
      while (!ctrl_busy && n < 50) begin @(posedge clk); #1; n++; end
    end
    check("abort_running", int'(ctrl_busy), 1);
    push_job(1, 2, 3, 12, 5);
    push_job(2, 2, 2, 13, 5);
    push_job(3, 1, 4, 14, 5);
    bus.job_valid = 1'b0;
    check("abort_queue_before", int'(bus.queue_count), 3);
    bus.abort = 1'b1;
    bus.job_valid = 1'b1;
    bus.job_m = DIM_W'(1);
    bus.job_k = DIM_W'(1);
    bus.job_n = DIM_W'(1);
    bus.job_tag = TAG_W'(15);
    #1;
    check("abort_blocks_push", int'(bus.job_ready), 0);
    @(posedge clk); #1;
    bus.abort = 1'b0;
    bus.job_valid = 1'b0;
    check("abort_queue_after", int'(bus.queue_count), 0);
    repeat (3) begin
      void'(exp_q.pop_back());
      void'(busy_len_q.pop_back());
      void'(exp_dims_q.pop_back());
      exp_launch--;
    end
    wait_drain("abort");

    // randomized traffic
    rand_ready = 1'b1;
    for (int j = 0; j < 25; j++) begin
      int m, k, n, len;
      if ($urandom_range(0, 3) == 0) begin
        m = $urandom_range(0, 5);
        k = $urandom_range(0, 5);
        n = $urandom_range(0, 5);
      end else begin
        m = $urandom_range(1, 4);
        k = $urandom_range(1, 4);
        n = $urandom_range(1, 4);
      end
      len = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 12);
      push_job(m, k, n, j % 16, len);
      idle($urandom_range(0, 3));
    end
    idle(1);
    wait_drain("random");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
